// File: rtl/truth_table_sequencer.sv
// Drives all eight {a,b,c} vectors into a 3-input circuit, samples x after a settle
// delay, and publishes the collected truth table with pass/mismatch statistics.
module truth_table_sequencer #(
    parameter int         SETTLE   = 2,
    parameter logic [7:0] EXPECTED = 8'h90
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       x,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] table_out,
    output logic [3:0] fail_count,
    output logic [2:0] first_fail,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic [7:0] work;
    logic [7:0] diff;
    logic [3:0] diff_count;
    logic [2:0] diff_first;

    assign state_dbg = state;
    assign diff      = work ^ EXPECTED;

    // Scanning downward leaves the lowest mismatching index as the final assignment.
    always_comb begin
        diff_count = 4'd0;
        diff_first = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            diff_count = diff_count + {3'b000, diff[i]};
            if (diff[i]) begin
                diff_first = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 3'd0;
            cnt        <= 4'd0;
            work       <= 8'h00;
            {a, b, c}  <= 3'b000;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            table_out  <= 8'h00;
            fail_count <= 4'd0;
            first_fail <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state     <= DRIVE;
                        idx       <= 3'd0;
                        cnt       <= 4'd0;
                        work      <= 8'h00;
                        {a, b, c} <= 3'b000;
                        busy      <= 1'b1;
                    end
                end
                DRIVE: begin
                    // Abort wins over a sample landing on the same edge.
                    if (abort) begin
                        state     <= IDLE;
                        {a, b, c} <= 3'b000;
                        busy      <= 1'b0;
                    end else if (cnt == SETTLE_CNT) begin
                        work[idx] <= x;
                        cnt       <= 4'd0;
                        if (idx == 3'd7) begin
                            state     <= REPORT;
                            {a, b, c} <= 3'b000;
                        end else begin
                            idx       <= idx + 3'd1;
                            {a, b, c} <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                REPORT: begin
                    table_out  <= work;
                    pass       <= (work == EXPECTED);
                    fail_count <= diff_count;
                    first_fail <= diff_first;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    {a, b, c} <= 3'b000;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
